// File: rtl/spi_peripheral.sv
// spi_peripheral: byte-oriented SPI slave. SCK, CS_n and MOSI are oversampled
// in the i_Clk domain. Received bytes are delivered as one-cycle pulses.
// Transmit bytes pass through a single-entry holding register and go out on MISO.
module spi_peripheral #(
   parameter int SPI_MODE = 0
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_TX_DV,
   output logic       o_TX_Ready,
   output logic       o_TX_Underrun,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   input  logic       i_SPI_Clk,
   input  logic       i_SPI_CS_n,
   input  logic       i_SPI_MOSI,
   output logic       o_SPI_MISO,
   output logic       o_SPI_MISO_En
);

   localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
   localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t     state, state_nxt;
   logic       sck_p0, sck_p1, sck_p2;
   logic       cs_p0, cs_p1, cs_p2;
   logic       mosi_p0, mosi_p1;
   logic [2:0] bit_cnt;
   logic       hold_vld;
   logic [7:0] hold_byte;
   logic [6:0] tx_shift;
   logic [6:0] rx_shift;
   logic       sck_lead, sck_trail, cs_fall, cs_rise;
   logic       sample_ev, shift_ev, sel_start, byte_start, drop;

   // p1 is the synchronised level, p2 the previous one; their difference is an edge
   assign sck_lead   = (sck_p2 == CPOL) && (sck_p1 != CPOL);
   assign sck_trail  = (sck_p2 != CPOL) && (sck_p1 == CPOL);
   assign cs_fall    = cs_p2 && !cs_p1;
   assign cs_rise    = !cs_p2 && cs_p1;
   assign o_TX_Ready = !hold_vld;

   // Two-stage synchronisers plus the edge-detect register
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         {sck_p0, sck_p1, sck_p2} <= {3{CPOL}};
         {cs_p0, cs_p1, cs_p2}    <= 3'b111;
         {mosi_p0, mosi_p1}       <= 2'b00;
      end else begin
         {sck_p0, sck_p1, sck_p2} <= {i_SPI_Clk, sck_p0, sck_p1};
         {cs_p0, cs_p1, cs_p2}    <= {i_SPI_CS_n, cs_p0, cs_p1};
         {mosi_p0, mosi_p1}       <= {i_SPI_MOSI, mosi_p0};
      end
   end

   // State register
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: selection follows the synchronised CS_n
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cs_fall) state_nxt = ACTIVE;
         ACTIVE:  if (cs_rise) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Event decode: SCK edges only count while selected and CS_n is still low
   always_comb begin
      sample_ev = 1'b0;
      shift_ev  = 1'b0;
      sel_start = 1'b0;
      drop      = 1'b0;
      case (state)
         IDLE: sel_start = cs_fall;
         ACTIVE: begin
            drop = cs_rise;
            if (!cs_p1) begin
               sample_ev = CPHA ? sck_trail : sck_lead;
               shift_ev  = CPHA ? sck_lead  : sck_trail;
            end
         end
         default: ;
      endcase
      // A shift edge at bit_cnt=7 is either the first edge of a CPHA=1 byte or,
      // for CPHA=0, the edge right after the previous byte's 8th sample
      byte_start = (sel_start && !CPHA) || (shift_ev && (bit_cnt == 3'd7));
   end

   // Holding register occupancy; a write racing an empty byte start survives it
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst)                      hold_vld <= 1'b0;
      else if (i_TX_DV && !hold_vld)  hold_vld <= 1'b1;
      else if (byte_start)            hold_vld <= 1'b0;
   end

   // Holding register data
   always_ff @(posedge i_Clk) begin
      if (i_TX_DV && !hold_vld) hold_byte <= i_TX_Byte;
   end

   // Shift register data; bit 7 goes straight to MISO so only 7 bits are kept
   always_ff @(posedge i_Clk) begin
      if (byte_start)    tx_shift <= hold_vld ? hold_byte[6:0] : 7'h00;
      else if (shift_ev) tx_shift <= {tx_shift[5:0], 1'b0};
      if (sample_ev)     rx_shift <= {rx_shift[5:0], mosi_p1};
   end

   // Bit counter and received-byte delivery; a deselect discards the partial byte
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         bit_cnt   <= 3'd7;
         o_RX_DV   <= 1'b0;
         o_RX_Byte <= 8'h00;
      end else begin
         o_RX_DV <= 1'b0;
         if (drop) begin
            bit_cnt <= 3'd7;
         end else if (sample_ev) begin
            if (bit_cnt == 3'd0) begin
               o_RX_Byte <= {rx_shift, mosi_p1};
               o_RX_DV   <= 1'b1;
               bit_cnt   <= 3'd7;
            end else begin
               bit_cnt <= bit_cnt - 3'd1;
            end
         end
      end
   end

   // MISO, its enable and the underrun pulse
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_SPI_MISO    <= 1'b0;
         o_SPI_MISO_En <= 1'b0;
         o_TX_Underrun <= 1'b0;
      end else begin
         o_TX_Underrun <= byte_start && !hold_vld;
         if (drop) begin
            o_SPI_MISO    <= 1'b0;
            o_SPI_MISO_En <= 1'b0;
         end else begin
            if (sel_start)       o_SPI_MISO_En <= 1'b1;
            if (byte_start)      o_SPI_MISO    <= hold_vld ? hold_byte[7] : 1'b0;
            else if (shift_ev)   o_SPI_MISO    <= tx_shift[6];
         end
      end
   end

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: drives a mode-0 and a mode-3 instance from a bit-level SPI
// master and checks them against a transaction-level model of the link.
module tb_spi_peripheral;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_byte [2];
   logic       tx_dv   [2];
   logic       tx_ready[2];
   logic       tx_und  [2];
   logic       rx_dv   [2];
   logic [7:0] rx_byte [2];
   logic       sck     [2];
   logic       cs_n    [2];
   logic       mosi    [2];
   logic       miso    [2];
   logic       miso_en [2];

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   logic [7:0] exp_rx0[$];
   logic [7:0] exp_rx1[$];
   int         exp_und [2];
   logic [7:0] last_rx [2];
   int         rx_seen [2];
   int         und_seen[2];
   int         lo_cnt  [2];
   int         hi_cnt  [2];

   // per-transfer stimulus
   logic [7:0] m_out [8];
   logic [7:0] m_in  [8];
   logic [7:0] tx_val[8];
   logic       tx_sup[8];
   int         half;

   always #5 clk = ~clk;

   spi_peripheral #(.SPI_MODE(0)) u0 (
      .i_Clk(clk), .i_Rst(rst),
      .i_TX_Byte(tx_byte[0]), .i_TX_DV(tx_dv[0]),
      .o_TX_Ready(tx_ready[0]), .o_TX_Underrun(tx_und[0]),
      .o_RX_DV(rx_dv[0]), .o_RX_Byte(rx_byte[0]),
      .i_SPI_Clk(sck[0]), .i_SPI_CS_n(cs_n[0]), .i_SPI_MOSI(mosi[0]),
      .o_SPI_MISO(miso[0]), .o_SPI_MISO_En(miso_en[0])
   );

   spi_peripheral #(.SPI_MODE(3)) u3 (
      .i_Clk(clk), .i_Rst(rst),
      .i_TX_Byte(tx_byte[1]), .i_TX_DV(tx_dv[1]),
      .o_TX_Ready(tx_ready[1]), .o_TX_Underrun(tx_und[1]),
      .o_RX_DV(rx_dv[1]), .o_RX_Byte(rx_byte[1]),
      .i_SPI_Clk(sck[1]), .i_SPI_CS_n(cs_n[1]), .i_SPI_MOSI(mosi[1]),
      .o_SPI_MISO(miso[1]), .o_SPI_MISO_En(miso_en[1])
   );

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h, want %02h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check32(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input int d);
      check8("rst_tx_ready", {7'd0, tx_ready[d]}, 8'h01);
      check8("rst_underrun", {7'd0, tx_und[d]},   8'h00);
      check8("rst_rx_dv",    {7'd0, rx_dv[d]},    8'h00);
      check8("rst_rx_byte",  rx_byte[d],          8'h00);
      check8("rst_miso",     {7'd0, miso[d]},     8'h00);
      check8("rst_miso_en",  {7'd0, miso_en[d]},  8'h00);
   endtask

   // Per-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      logic [7:0] e;
      for (int d = 0; d < 2; d++) begin
         if (rst !== 1'b0) begin
            last_rx[d] = 8'h00;
            lo_cnt[d]  = 0;
            hi_cnt[d]  = 0;
         end else begin
            if (rx_dv[d] === 1'b1) begin
               rx_seen[d]++;
               if ((d == 0 && exp_rx0.size() == 0) || (d == 1 && exp_rx1.size() == 0)) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL rx_unexpected dev%0d: got %02h, want no byte", d, rx_byte[d]);
               end else begin
                  e = (d == 0) ? exp_rx0.pop_front() : exp_rx1.pop_front();
                  check8("rx_byte", rx_byte[d], e);
                  last_rx[d] = e;
               end
            end else begin
               check8("rx_hold", rx_byte[d], last_rx[d]);
            end
            if (tx_und[d] === 1'b1) begin
               und_seen[d]++;
               n_chk++;
               if (exp_und[d] == 0) begin
                  n_fail++;
                  $display("FAIL underrun dev%0d: got pulse, want none", d);
               end else begin
                  exp_und[d]--;
               end
            end
            if (cs_n[d]) begin hi_cnt[d]++; lo_cnt[d] = 0; end
            else         begin lo_cnt[d]++; hi_cnt[d] = 0; end
            if (hi_cnt[d] > 4) begin
               check8("miso_en_deselected", {7'd0, miso_en[d]}, 8'h00);
               check8("miso_deselected",    {7'd0, miso[d]},    8'h00);
            end
            if (lo_cnt[d] > 4)
               check8("miso_en_selected", {7'd0, miso_en[d]}, 8'h01);
         end
      end
   end

   // Write the holding register, then show that a second write is ignored
   task automatic write_tx(input int d, input logic [7:0] v);
      check8("tx_ready_before_write", {7'd0, tx_ready[d]}, 8'h01);
      tx_byte[d] = v;
      tx_dv[d]   = 1'b1;
      @(negedge clk);
      tx_byte[d] = ~v;
      check8("tx_ready_after_write", {7'd0, tx_ready[d]}, 8'h00);
      @(negedge clk);
      tx_dv[d] = 1'b0;
      check8("tx_ready_ignored_write", {7'd0, tx_ready[d]}, 8'h00);
   endtask

   // Supplies bytes 1..nb-1 once the previous byte has been taken
   task automatic feeder(input int d, input int nb);
      logic prev;
      int   t;
      for (int i = 1; i < nb; i++) begin
         t    = 0;
         prev = tx_ready[d];
         while (t < 400) begin
            @(negedge clk);
            if (tx_und[d] || (tx_ready[d] && !prev)) break;
            prev = tx_ready[d];
            t++;
         end
         if (t >= 400) check32("byte_start_timeout", t, 0);
         else if (tx_sup[i]) write_tx(d, tx_val[i]);
      end
   endtask

   // Bit-level SPI master; stop_cyc>0 deselects (or resets) after that many SCK cycles
   task automatic spi_master(input int d, input int nb, input int stop_cyc, input bit do_rst);
      logic pol;
      bit   cpha;
      bit   stop;
      int   k;
      pol  = (d == 1);
      cpha = (d == 1);
      stop = 1'b0;
      k    = 0;
      cs_n[d] = 1'b0;
      if (!cpha) mosi[d] = m_out[0][7];
      wait_clk(half + 2);
      for (int i = 0; i < nb && !stop; i++) begin
         for (int b = 7; b >= 0 && !stop; b--) begin
            if (stop_cyc != 0 && k == stop_cyc) begin
               stop = 1'b1;
            end else begin
               if (cpha) begin
                  sck[d]  = ~pol;
                  mosi[d] = m_out[i][b];
               end
               wait_clk(half);
               m_in[i][b] = miso[d];
               sck[d] = cpha ? pol : ~pol;
               wait_clk(half);
               if (!cpha) begin
                  sck[d] = pol;
                  if (i == nb - 1 && b == 0) cs_n[d] = 1'b1;
                  else if (b == 0)           mosi[d] = m_out[i + 1][7];
                  else                       mosi[d] = m_out[i][b - 1];
               end
               k++;
            end
         end
      end
      if (stop && do_rst) begin
         rst = 1'b1;
         #1;
         check_reset_outputs(0);
         check_reset_outputs(1);
         cs_n[d] = 1'b1;
         wait_clk(3);
         rst = 1'b0;
      end else begin
         wait_clk(2);
         cs_n[d] = 1'b1;
      end
      wait_clk(half + 6);
   endtask

   // One transfer: derive expectations from the link rules, run it, check results
   task automatic run_xfer(input int d, input int nb, input int stop_cyc, input bit do_rst);
      int s_rx, s_und, started, n_und;
      started = (stop_cyc == 0) ? nb : 1;
      n_und   = 0;
      for (int i = 0; i < started; i++) if (!tx_sup[i]) n_und++;
      if (stop_cyc == 0)
         for (int i = 0; i < nb; i++) begin
            if (d == 0) exp_rx0.push_back(m_out[i]);
            else        exp_rx1.push_back(m_out[i]);
         end
      exp_und[d] += n_und;
      s_rx  = rx_seen[d];
      s_und = und_seen[d];
      if (tx_sup[0]) write_tx(d, tx_val[0]);
      fork
         spi_master(d, nb, stop_cyc, do_rst);
         feeder(d, nb);
      join
      check32("rx_count", rx_seen[d] - s_rx, (stop_cyc == 0) ? nb : 0);
      check32("underrun_count", und_seen[d] - s_und, n_und);
      check32("rx_pending", (d == 0) ? exp_rx0.size() : exp_rx1.size(), 0);
      if (stop_cyc == 0)
         for (int i = 0; i < nb; i++)
            check8("master_rx", m_in[i], tx_sup[i] ? tx_val[i] : 8'h00);
      exp_und[d] = 0;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, want finish before 800000 ns");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         tx_byte[d] = 8'h00; tx_dv[d] = 1'b0;
         cs_n[d] = 1'b1; mosi[d] = 1'b0;
         exp_und[d] = 0; last_rx[d] = 8'h00;
         rx_seen[d] = 0; und_seen[d] = 0; lo_cnt[d] = 0; hi_cnt[d] = 0;
      end
      sck[0] = 1'b0;
      sck[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tx_sup[i] = 1'b0; tx_val[i] = 8'h00; m_out[i] = 8'h00; m_in[i] = 8'h00;
      end
      half = 4;
      #1 rst = 1'b1;
      wait_clk(3);
      check_reset_outputs(0);
      check_reset_outputs(1);
      rst = 1'b0;
      wait_clk(4);

      // mode 0 single byte
      m_out[0] = 8'h3C; tx_sup[0] = 1'b1; tx_val[0] = 8'hA5;
      run_xfer(0, 1, 0, 1'b0);
      check8("m0_rx_byte", rx_byte[0], 8'h3C);
      check8("m0_master_rx", m_in[0], 8'hA5);

      // mode 0 back-to-back
      m_out[0] = 8'hF0; m_out[1] = 8'h0F;
      tx_sup[0] = 1'b1; tx_val[0] = 8'h12; tx_sup[1] = 1'b1; tx_val[1] = 8'h34;
      run_xfer(0, 2, 0, 1'b0);
      check8("b2b_rx_last", rx_byte[0], 8'h0F);
      check8("b2b_master_rx0", m_in[0], 8'h12);
      check8("b2b_master_rx1", m_in[1], 8'h34);

      // underrun
      m_out[0] = 8'h55; tx_sup[0] = 1'b0;
      run_xfer(0, 1, 0, 1'b0);
      check8("und_rx_byte", rx_byte[0], 8'h55);
      check8("und_master_rx", m_in[0], 8'h00);

      // abort after 5 SCK cycles, then a clean transfer
      m_out[0] = 8'hFF; tx_sup[0] = 1'b1; tx_val[0] = 8'hE7;
      run_xfer(0, 1, 5, 1'b0);
      check8("abort_rx_unchanged", rx_byte[0], 8'h55);
      m_out[0] = 8'hC3; tx_sup[0] = 1'b1; tx_val[0] = 8'h5A;
      run_xfer(0, 1, 0, 1'b0);
      check8("post_abort_rx", rx_byte[0], 8'hC3);
      check8("post_abort_master_rx", m_in[0], 8'h5A);

      // mode 3
      m_out[0] = 8'h7E; tx_sup[0] = 1'b1; tx_val[0] = 8'h81;
      run_xfer(1, 1, 0, 1'b0);
      check8("m3_rx_byte", rx_byte[1], 8'h7E);
      check8("m3_master_rx", m_in[0], 8'h81);

      // reset after 3 bits, then a fresh transfer
      m_out[0] = 8'hAA; tx_sup[0] = 1'b1; tx_val[0] = 8'h66;
      run_xfer(0, 1, 3, 1'b1);
      check8("post_rst_ready", {7'd0, tx_ready[0]}, 8'h01);
      m_out[0] = 8'h99; tx_sup[0] = 1'b1; tx_val[0] = 8'h24;
      run_xfer(0, 1, 0, 1'b0);
      check8("post_rst_rx", rx_byte[0], 8'h99);
      check8("post_rst_master_rx", m_in[0], 8'h24);

      // randomized transfers on both modes
      for (int n = 0; n < 24; n++) begin
         int d, nb;
         d    = $urandom_range(0, 1);
         nb   = $urandom_range(1, 3);
         half = $urandom_range(4, 6);
         for (int i = 0; i < nb; i++) begin
            m_out[i]  = 8'($urandom);
            tx_val[i] = 8'($urandom);
            tx_sup[i] = ($urandom_range(0, 3) != 0);
         end
         run_xfer(d, nb, 0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

Byte-oriented SPI peripheral (slave). It is the far-end counterpart of the team's SPI master, used for loopback and board-to-board links. External SCK, CS_n and MOSI are oversampled in the fabric clock domain. Received bytes are delivered as one-cycle valid pulses. Transmit bytes are supplied through a single-entry holding register with a ready/valid handshake and shifted out on MISO.

## Interface
- SPI_MODE, 0: CPOL = (mode 2 or 3); CPHA = (mode 1 or 3); same mode numbering as the master.
- i_Clk  in  1  fabric clock; SCK half-period must be at least 4 i_Clk periods.
- i_Rst  in  1  asynchronous, active-high reset.
- i_TX_Byte  in  8  next byte to send on MISO, MSb first.
- i_TX_DV  in  1  write strobe for i_TX_Byte; accepted only while o_TX_Ready=1.
- o_TX_Ready  out  1  holding register empty.
- o_TX_Underrun  out  1  one-cycle pulse: a byte started with the holding register empty.
- o_RX_DV  out  1  one-cycle pulse: o_RX_Byte is valid.
- o_RX_Byte  out  8  last complete received byte, MSb first.
- i_SPI_Clk  in  1  SCK from the master (asynchronous).
- i_SPI_CS_n  in  1  chip select, active low (asynchronous).
- i_SPI_MOSI  in  1  serial data in (asynchronous).
- o_SPI_MISO  out  1  serial data out.
- o_SPI_MISO_En  out  1  output enable for the external tristate buffer; 1 only while selected.

## Operation
- **Synchronisers.** SCK, CS_n and MOSI each pass through a 2-FF synchroniser, followed by a third register used for edge detection. Reset values: SCK = CPOL, CS_n = 1, MOSI = 0.
- **Edge events.** All events are derived from the synchronised signals:
  - leading edge: SCK leaves its CPOL idle level.
  - trailing edge: SCK returns to CPOL.
  - sample edge: leading edge if CPHA=0, trailing edge if CPHA=1.
  - shift edge: the other SCK edge.
  - SCK edges are ignored while CS_n is high.
- **States.**
  - IDLE → ACTIVE on synchronised CS_n falling.
  - ACTIVE → IDLE on synchronised CS_n rising, from any bit position.
- **Byte start.** Byte start is when the holding register moves to the TX shift register.
  - CPHA=0: on CS_n falling, and on the shift edge that follows the 8th sample while CS_n stays low. MISO is driven with bit 7 in the same cycle.
  - CPHA=1: on the first shift edge of each byte, i.e. when bit_cnt=7. Bit 7 is driven on that edge.
- **Underrun.** If the holding register is empty at byte start, the shift register loads 8'h00 and o_TX_Underrun pulses.
- **MISO.** Each subsequent shift edge within the byte drives the next lower bit.
- **Receive.** On each sample edge, rx_shift <= {rx_shift[6:0], MOSI_sync} and bit_cnt decrements.
  - On the sample edge with bit_cnt=0: o_RX_Byte <= {rx_shift[6:0], MOSI_sync}, o_RX_DV pulses for one cycle, and bit_cnt returns to 7.
  - o_RX_Byte holds its value until the next completed byte.
- **TX handshake.**
  - i_TX_DV while o_TX_Ready=1 writes the holding register; o_TX_Ready goes low on the next cycle.
  - i_TX_DV while o_TX_Ready=0 is ignored; the held byte is unchanged.
  - o_TX_Ready rises on the cycle after a byte start consumes the holding register.
- **Simultaneous i_TX_DV and byte start with the holding register empty.** The byte start sees "empty": it sends 8'h00 and pulses underrun. The written byte is kept for the next byte.
- **CS_n rising mid-byte.**
  - Partial RX is discarded; no o_RX_DV.
  - bit_cnt returns to 7.
  - The consumed TX byte is lost; the holding register is untouched.
  - o_SPI_MISO_En=0 and o_SPI_MISO=0 on the cycle after the synchronised CS_n rise.
- **Reset (any time, including mid-transfer).** Returns to IDLE with outputs: o_TX_Ready=1, o_TX_Underrun=0, o_RX_DV=0, o_RX_Byte=8'h00, o_SPI_MISO=0, o_SPI_MISO_En=0. The holding register is emptied; bit_cnt=7.

## Timing
- Pin-to-action latency is 3 i_Clk rising edges at most from an input transition to the registered action (2 synchroniser stages plus the edge register).
- o_RX_DV is asserted on the cycle following detection of the 8th sample edge.
- A MISO change lags the SCK shift edge by at most 4 i_Clk cycles. This fits within one SCK half-period given the ≥4-cycle requirement.
- o_SPI_MISO_En rises one cycle after the synchronised CS_n falls, together with bit 7 when CPHA=0.
- Back-to-back bytes need no gap. The next byte's holding register must be written before its byte start to avoid underrun.

## Test plan
- **Mode 0 single byte:** preload 8'hA5, master sends 8'h3C at 4 i_Clk per SCK half-period → o_RX_DV pulses once with o_RX_Byte=8'h3C; master receives 8'hA5; o_TX_Underrun never pulses.
- **Mode 0 back-to-back:** preload 8'h12; write 8'h34 after o_TX_Ready rises; master sends 8'hF0, 8'h0F under one CS_n → two o_RX_DV pulses (F0, 0F); master receives 12, 34.
- **Underrun:** no preload, master sends 8'h55 → MISO byte 8'h00; o_TX_Underrun pulses once at CS_n fall; o_RX_Byte=8'h55.
- **Abort:** CS_n rises after 5 SCK cycles → no o_RX_DV; o_SPI_MISO_En drops within 4 cycles. The next full transfer of 8'hC3 is received correctly as 8'hC3.
- **Mode 3 (CPOL=1, CPHA=1):** preload 8'h81, master sends 8'h7E → o_RX_Byte=8'h7E; master receives 8'h81.
- **Reset mid-byte:** assert i_Rst after 3 bits → all outputs take reset values immediately. After release, a fresh 8'h99 transfer decodes as 8'h99.
